msrv32_pc_reg_block: RTL and testbench
======================================

// Module: msrv32_pc_reg_block
// PURPOSE
//  Parametrised PC register for the fetch stage; successor to the plain PC flop. Holds the
//  current fetch PC, advances it to the PC-mux result only on an accepted fetch, and supports
//  stall, trap redirect, boot delay and misaligned-target detection. Sits between the PC mux
//  and instruction memory/IF-ID register, and supplies the previous PC to decode.
// PARAMETERS
//  XLEN          32             PC width in bits
//  RESET_VECTOR  32'h0000_0000  PC value held during reset and boot
//  BOOT_DELAY    2              rising edges in BOOT before fetch starts (0..255)
//  IALIGN        4              instruction alignment in bytes (2 or 4); ALIGN_BITS = $clog2(IALIGN)
// PORTS
//  ms_riscv32_mp_clk_in      in   1     clock, rising edge
//  ms_riscv32_mp_rst_n_in    in   1     asynchronous reset, active-low
//  pc_mux_in                 in   XLEN  next PC from PC mux
//  imem_ready_in             in   1     instruction memory can accept a fetch this cycle
//  stall_in                  in   1     pipeline stall; hold PC
//  trap_in                   in   1     trap/exception redirect request
//  trap_vector_in            in   XLEN  trap target address
//  pc_out                    out  XLEN  current fetch PC
//  pc_prev_out               out  XLEN  PC of last accepted fetch (to IF/ID)
//  pc_valid_out              out  1     pc_out is a valid fetch request
//  misaligned_out            out  1     misaligned next-PC detected; fetch frozen
//  misaligned_addr_out       out  XLEN  offending pc_mux_in value
//  boot_done_out             out  1     BOOT finished (sticky until reset)
//  fetch_count_out           out  32    count of accepted fetches, wraps 2^32-1 -> 0
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=BOOT, boot_cnt=0, pc_out=pc_prev_out=RESET_VECTOR,
//    pc_valid_out=0, misaligned_out=0, misaligned_addr_out=0, boot_done_out=0, fetch_count_out=0.
//  - States: BOOT, RUN, MISALIGNED. pc_valid_out = (state==RUN), combinational from state.
//  - BOOT: each edge boot_cnt++; on edge with boot_cnt==BOOT_DELAY -> RUN, boot_done_out<=1.
//    pc_valid_out first high after edge BOOT_DELAY+1 (edge 1 when BOOT_DELAY=0).
//    stall_in, trap_in, imem_ready_in ignored in BOOT.
//  - accept = RUN && imem_ready_in && !stall_in && !trap_in.
//  - RUN, accept, pc_mux_in[ALIGN_BITS-1:0]==0: pc_prev_out<=pc_out, pc_out<=pc_mux_in,
//    fetch_count_out++ (1-cycle latency, stays RUN).
//  - RUN, accept, pc_mux_in low bits !=0: -> MISALIGNED; pc_out, pc_prev_out, count unchanged;
//    misaligned_out<=1, misaligned_addr_out<=pc_mux_in.
//  - RUN, no accept, no trap: all registers hold.
//  - trap_in in RUN or MISALIGNED (priority over stall, ready, misalign):
//    pc_out<={trap_vector_in[XLEN-1:ALIGN_BITS], ALIGN_BITS'b0}; pc_prev_out, count unchanged;
//    misaligned_out<=0 (misaligned_addr_out retained); state -> RUN.
//  - MISALIGNED: only trap_in exits; pc_valid_out=0; all else holds.
//  - Reset asserted mid-operation: immediate return to reset values, no partial update.
// STRUCTURE
//  - Shared package msrv32_pkg: state enum localparams (BOOT=2'd0, RUN=2'd1, MISALIGNED=2'd2),
//    align_mask helper function for IALIGN.
//  - One sub-module: msrv32_boot_counter (8-bit counter, async active-low reset, done pulse at
//    BOOT_DELAY). All other logic inline: state FSM, PC/prev regs, count, misalign check.
// TESTING
//  1 Reset/boot: RESET_VECTOR=32'h100, BOOT_DELAY=2, release rst_n -> pc_valid_out=0 edges 1-2,
//    =1 after edge 3, pc_out=32'h100, boot_done_out=1.
//  2 Sequential fetch: ready=1, pc_mux_in=pc_out+4 for 5 cycles -> pc_out=32'h114,
//    pc_prev_out=32'h110, fetch_count_out=5.
//  3 Stall/ready: stall_in=1 2 cycles then ready=0 1 cycle -> pc_out and count frozen; resume
//    advances on next accepted edge only.
//  4 Misaligned: pc_mux_in=32'h202 (IALIGN=4) -> misaligned_out=1, addr=32'h202, pc_valid_out=0,
//    pc_out unchanged; IALIGN=2 same stimulus -> accepted normally.
//  5 Trap priority: trap_in=1 with stall_in=1, trap_vector_in=32'h8000_0003 -> pc_out=32'h8000_0000,
//    RUN, misaligned_out=0, count unchanged; also exits MISALIGNED.
//  6 Async reset mid-run + wrap: drop rst_n between edges -> outputs reset immediately; preload
//    count 32'hFFFF_FFFF via force, one accept -> 0.

Source files
------------

// File: rtl/msrv32_pkg.sv
// ---------------------------------------------------------------------------
// msrv32_pkg
//   Shared definitions for the fetch-stage PC register:
//   - pc_state_t : PC register FSM states (BOOT, RUN, MISALIGNED)
//   - BOOT_CNT_W : width of the boot-delay counter
//   - align_mask : low-address-bit mask for a given instruction alignment
// ---------------------------------------------------------------------------
package msrv32_pkg;

  typedef enum logic [1:0] {
    BOOT       = 2'd0,
    RUN        = 2'd1,
    MISALIGNED = 2'd2
  } pc_state_t;

  localparam int unsigned BOOT_CNT_W = 8;

  // Mask selecting the address bits that must be zero for an aligned
  // instruction (IALIGN=4 -> 32'h3, IALIGN=2 -> 32'h1).
  function automatic logic [31:0] align_mask(input int unsigned ialign);
    return 32'(ialign) - 32'd1;
  endfunction

endpackage

// File: rtl/msrv32_boot_counter.sv
// ---------------------------------------------------------------------------
// msrv32_boot_counter
//   8-bit boot-delay counter. Counts every rising edge while enabled and
//   raises done while enabled and the count equals BOOT_DELAY, so the owner
//   leaves BOOT on the edge where the count has reached BOOT_DELAY.
// Ports
//   clk    in  rising-edge clock
//   rst_n  in  asynchronous active-low reset (count -> 0)
//   en     in  count enable (owner is in BOOT)
//   done   out boot delay elapsed
// ---------------------------------------------------------------------------
module msrv32_boot_counter
  import msrv32_pkg::*;
#(
  parameter int unsigned BOOT_DELAY = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic done
);

  logic [BOOT_CNT_W-1:0] cnt;

  // Boot counter register: advances once per edge while enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 8'd1;
    end else begin
      cnt <= cnt;
    end
  end

  // Done decode against the configured delay.
  always_comb begin
    done = 1'b0;
    if (en && (cnt == BOOT_CNT_W'(BOOT_DELAY))) begin
      done = 1'b1;
    end else begin
      done = 1'b0;
    end
  end

endmodule

// File: rtl/msrv32_pc_reg_block.sv
// ---------------------------------------------------------------------------
// msrv32_pc_reg_block
//   Fetch-stage PC register. Holds the current fetch PC and advances it to
//   the PC-mux value on an accepted fetch. Supports pipeline stall, trap
//   redirect (highest priority), a boot delay after reset and detection of
//   misaligned next-PC values, which freeze fetch until a trap.
// Ports
//   ms_riscv32_mp_clk_in    in   clock, rising edge
//   ms_riscv32_mp_rst_n_in  in   asynchronous active-low reset
//   pc_mux_in               in   next PC from the PC mux
//   imem_ready_in           in   instruction memory can take a fetch
//   stall_in                in   pipeline stall, hold PC
//   trap_in                 in   trap redirect request
//   trap_vector_in          in   trap target (low bits forced to alignment)
//   pc_out                  out  current fetch PC
//   pc_prev_out             out  PC of the last accepted fetch
//   pc_valid_out            out  pc_out is a valid fetch request (RUN)
//   misaligned_out          out  misaligned next PC seen, fetch frozen
//   misaligned_addr_out     out  offending next PC
//   boot_done_out           out  boot delay finished (sticky)
//   fetch_count_out         out  accepted fetch count, wraps
// ---------------------------------------------------------------------------
module msrv32_pc_reg_block
  import msrv32_pkg::*;
#(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned     BOOT_DELAY   = 2,
  parameter int unsigned     IALIGN       = 4
) (
  input  logic            ms_riscv32_mp_clk_in,
  input  logic            ms_riscv32_mp_rst_n_in,
  input  logic [XLEN-1:0] pc_mux_in,
  input  logic            imem_ready_in,
  input  logic            stall_in,
  input  logic            trap_in,
  input  logic [XLEN-1:0] trap_vector_in,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] pc_prev_out,
  output logic            pc_valid_out,
  output logic            misaligned_out,
  output logic [XLEN-1:0] misaligned_addr_out,
  output logic            boot_done_out,
  output logic [31:0]     fetch_count_out
);

  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(align_mask(IALIGN));

  pc_state_t       state;
  pc_state_t       state_nxt;
  logic [XLEN-1:0] pc_nxt;
  logic [XLEN-1:0] pc_prev_nxt;
  logic            misaligned_nxt;
  logic [XLEN-1:0] misaligned_addr_nxt;
  logic            boot_done_nxt;
  logic [31:0]     fetch_count_nxt;
  logic            boot_expired;
  logic            accept;
  logic            target_misaligned;
  logic [XLEN-1:0] trap_target;

  msrv32_boot_counter #(
    .BOOT_DELAY (BOOT_DELAY)
  ) u_boot_counter (
    .clk   (ms_riscv32_mp_clk_in),
    .rst_n (ms_riscv32_mp_rst_n_in),
    .en    (state == BOOT),
    .done  (boot_expired)
  );

  assign pc_valid_out      = (state == RUN);
  assign accept            = (state == RUN) && imem_ready_in && !stall_in && !trap_in;
  assign target_misaligned = ((pc_mux_in & ALIGN_MASK) != '0);
  // Trap targets are forced onto the instruction alignment grid.
  assign trap_target       = trap_vector_in & ~ALIGN_MASK;

  // Next-state and next-register decode; trap outranks stall, ready and misalign.
  always_comb begin
    state_nxt           = state;
    pc_nxt              = pc_out;
    pc_prev_nxt         = pc_prev_out;
    misaligned_nxt      = misaligned_out;
    misaligned_addr_nxt = misaligned_addr_out;
    boot_done_nxt       = boot_done_out;
    fetch_count_nxt     = fetch_count_out;
    case (state)
      BOOT: begin
        if (boot_expired) begin
          state_nxt     = RUN;
          boot_done_nxt = 1'b1;
        end else begin
          state_nxt = BOOT;
        end
      end
      RUN: begin
        if (trap_in) begin
          pc_nxt         = trap_target;
          misaligned_nxt = 1'b0;
          state_nxt      = RUN;
        end else if (accept) begin
          if (target_misaligned) begin
            state_nxt           = MISALIGNED;
            misaligned_nxt      = 1'b1;
            misaligned_addr_nxt = pc_mux_in;
          end else begin
            pc_prev_nxt     = pc_out;
            pc_nxt          = pc_mux_in;
            fetch_count_nxt = fetch_count_out + 32'd1;
          end
        end else begin
          state_nxt = RUN;
        end
      end
      MISALIGNED: begin
        if (trap_in) begin
          pc_nxt         = trap_target;
          misaligned_nxt = 1'b0;
          state_nxt      = RUN;
        end else begin
          state_nxt = MISALIGNED;
        end
      end
      default: begin
        // Unreachable encoding: freeze fetch until a trap restores control.
        state_nxt      = MISALIGNED;
        misaligned_nxt = 1'b1;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
    if (!ms_riscv32_mp_rst_n_in) begin
      state               <= BOOT;
      pc_out              <= RESET_VECTOR;
      pc_prev_out         <= RESET_VECTOR;
      misaligned_out      <= 1'b0;
      misaligned_addr_out <= '0;
      boot_done_out       <= 1'b0;
      fetch_count_out     <= 32'd0;
    end else begin
      state               <= state_nxt;
      pc_out              <= pc_nxt;
      pc_prev_out         <= pc_prev_nxt;
      misaligned_out      <= misaligned_nxt;
      misaligned_addr_out <= misaligned_addr_nxt;
      boot_done_out       <= boot_done_nxt;
      fetch_count_out     <= fetch_count_nxt;
    end
  end

endmodule

// File: tb/tb_msrv32_pc_reg_block.sv
// ---------------------------------------------------------------------------
// tb_msrv32_pc_reg_block
//   Directed bench for the fetch PC register. dut4 uses IALIGN=4 and carries
//   most checks; dut2 (IALIGN=2) shares the stimulus and is checked where the
//   alignment changes the outcome.
// ---------------------------------------------------------------------------
module tb_msrv32_pc_reg_block;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc_mux;
  logic        ready;
  logic        stall;
  logic        trap;
  logic [31:0] trap_vec;

  logic [31:0] pc4, prev4, maddr4, cnt4;
  logic        valid4, mis4, bdone4;
  logic [31:0] pc2, prev2, maddr2, cnt2;
  logic        valid2, mis2, bdone2;

  int checks = 0;
  int errors = 0;

  msrv32_pc_reg_block #(
    .XLEN(32), .RESET_VECTOR(32'h0000_0100), .BOOT_DELAY(2), .IALIGN(4)
  ) dut4 (
    .ms_riscv32_mp_clk_in   (clk),
    .ms_riscv32_mp_rst_n_in (rst_n),
    .pc_mux_in              (pc_mux),
    .imem_ready_in          (ready),
    .stall_in               (stall),
    .trap_in                (trap),
    .trap_vector_in         (trap_vec),
    .pc_out                 (pc4),
    .pc_prev_out            (prev4),
    .pc_valid_out           (valid4),
    .misaligned_out         (mis4),
    .misaligned_addr_out    (maddr4),
    .boot_done_out          (bdone4),
    .fetch_count_out        (cnt4)
  );

  msrv32_pc_reg_block #(
    .XLEN(32), .RESET_VECTOR(32'h0000_0100), .BOOT_DELAY(2), .IALIGN(2)
  ) dut2 (
    .ms_riscv32_mp_clk_in   (clk),
    .ms_riscv32_mp_rst_n_in (rst_n),
    .pc_mux_in              (pc_mux),
    .imem_ready_in          (ready),
    .stall_in               (stall),
    .trap_in                (trap),
    .trap_vector_in         (trap_vec),
    .pc_out                 (pc2),
    .pc_prev_out            (prev2),
    .pc_valid_out           (valid2),
    .misaligned_out         (mis2),
    .misaligned_addr_out    (maddr2),
    .boot_done_out          (bdone2),
    .fetch_count_out        (cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] exp_pc;
  logic [31:0] exp_prev;

  initial begin
    rst_n    = 1'b0;
    pc_mux   = 32'h0;
    ready    = 1'b0;
    stall    = 1'b0;
    trap     = 1'b0;
    trap_vec = 32'h0;

    // Reset state
    step();
    step();
    chk("rst_pc",     pc4,            32'h100);
    chk("rst_prev",   prev4,          32'h100);
    chk("rst_valid",  {31'd0, valid4}, 32'd0);
    chk("rst_mis",    {31'd0, mis4},   32'd0);
    chk("rst_maddr",  maddr4,         32'h0);
    chk("rst_bdone",  {31'd0, bdone4}, 32'd0);
    chk("rst_cnt",    cnt4,           32'd0);

    // Boot: valid only after the third edge; inputs ignored meanwhile
    rst_n  = 1'b1;
    ready  = 1'b1;
    pc_mux = 32'h104;
    step();
    chk("boot_e1_valid", {31'd0, valid4}, 32'd0);
    chk("boot_e1_pc",    pc4,             32'h100);
    step();
    chk("boot_e2_valid", {31'd0, valid4}, 32'd0);
    chk("boot_e2_bdone", {31'd0, bdone4}, 32'd0);
    step();
    chk("boot_e3_valid", {31'd0, valid4}, 32'd1);
    chk("boot_e3_bdone", {31'd0, bdone4}, 32'd1);
    chk("boot_e3_pc",    pc4,             32'h100);
    chk("boot_e3_cnt",   cnt4,            32'd0);

    // Sequential fetch: five accepted +4 steps
    exp_pc   = 32'h100;
    exp_prev = 32'h100;
    for (int i = 0; i < 5; i++) begin
      pc_mux = exp_pc + 32'd4;
      step();
      exp_prev = exp_pc;
      exp_pc   = exp_pc + 32'd4;
      chk("seq_pc", pc4, exp_pc);
    end
    chk("seq_pc_final",   pc4,   32'h114);
    chk("seq_prev_final", prev4, 32'h110);
    chk("seq_cnt_final",  cnt4,  32'd5);

    // Stall two cycles, then not-ready one cycle: frozen
    pc_mux = 32'h118;
    stall  = 1'b1;
    step();
    chk("stall1_pc",  pc4,  32'h114);
    chk("stall1_cnt", cnt4, 32'd5);
    step();
    chk("stall2_pc",  pc4,  32'h114);
    stall = 1'b0;
    ready = 1'b0;
    step();
    chk("nrdy_pc",    pc4,  32'h114);
    chk("nrdy_cnt",   cnt4, 32'd5);
    chk("nrdy_valid", {31'd0, valid4}, 32'd1);
    ready = 1'b1;
    step();
    chk("resume_pc",   pc4,   32'h118);
    chk("resume_prev", prev4, 32'h114);
    chk("resume_cnt",  cnt4,  32'd6);

    // Misaligned target 0x202: frozen on IALIGN=4, accepted on IALIGN=2
    pc_mux = 32'h202;
    step();
    chk("mis_flag",   {31'd0, mis4},   32'd1);
    chk("mis_addr",   maddr4,          32'h202);
    chk("mis_valid",  {31'd0, valid4}, 32'd0);
    chk("mis_pc",     pc4,             32'h118);
    chk("mis_cnt",    cnt4,            32'd6);
    chk("a2_pc",      pc2,             32'h202);
    chk("a2_prev",    prev2,           32'h118);
    chk("a2_mis",     {31'd0, mis2},   32'd0);
    chk("a2_cnt",     cnt2,            32'd7);
    pc_mux = 32'h300;
    step();
    chk("mis_hold_pc",    pc4,             32'h118);
    chk("mis_hold_valid", {31'd0, valid4}, 32'd0);

    // Trap with stall exits MISALIGNED; target low bits cleared
    trap     = 1'b1;
    stall    = 1'b1;
    trap_vec = 32'h8000_0003;
    step();
    chk("trapm_pc",    pc4,             32'h8000_0000);
    chk("trapm_valid", {31'd0, valid4}, 32'd1);
    chk("trapm_mis",   {31'd0, mis4},   32'd0);
    chk("trapm_maddr", maddr4,          32'h202);
    chk("trapm_prev",  prev4,           32'h114);
    chk("trapm_cnt",   cnt4,            32'd6);
    chk("trapm_a2_pc", pc2,             32'h8000_0002);

    // Trap with stall from RUN
    trap_vec = 32'h4000_0007;
    step();
    chk("trapr_pc",  pc4,  32'h4000_0004);
    chk("trapr_cnt", cnt4, 32'd6);
    trap   = 1'b0;
    stall  = 1'b0;
    pc_mux = 32'h4000_0008;
    step();
    chk("post_trap_pc",   pc4,   32'h4000_0008);
    chk("post_trap_prev", prev4, 32'h4000_0004);
    chk("post_trap_cnt",  cnt4,  32'd7);

    // Async reset between edges takes effect without a clock edge
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_pc",    pc4,             32'h100);
    chk("arst_prev",  prev4,           32'h100);
    chk("arst_valid", {31'd0, valid4}, 32'd0);
    chk("arst_bdone", {31'd0, bdone4}, 32'd0);
    chk("arst_cnt",   cnt4,            32'd0);
    chk("arst_maddr", maddr4,          32'h0);
    step();
    rst_n    = 1'b1;
    trap     = 1'b1;
    trap_vec = 32'h500;
    step();
    chk("boot_trap_pc",    pc4,             32'h100);
    chk("boot_trap_valid", {31'd0, valid4}, 32'd0);
    trap = 1'b0;
    step();
    step();
    chk("reboot_valid", {31'd0, valid4}, 32'd1);

    // Counter wrap from all-ones
    force dut4.fetch_count_out = 32'hFFFF_FFFF;
    #1;
    release dut4.fetch_count_out;
    pc_mux = 32'h104;
    ready  = 1'b1;
    step();
    chk("wrap_cnt", cnt4, 32'd0);
    chk("wrap_pc",  pc4,  32'h104);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
